// File: rtl/dmg_dma_pkg.sv
// Shared types and constants for the OAM DMA sequencer and the bus source muxes.
package dmg_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } dma_state_e;

    localparam int         OAM_LEN      = 160;
    localparam logic [7:0] FF46_RESET   = 8'hFF;
    localparam logic [7:0] ECHO_BASE    = 8'hE0;
    localparam logic [7:0] ECHO_OFFSET  = 8'h20;
    localparam logic [2:0] VRAM_PAGE_HI = 3'b100;

endpackage

// File: rtl/dma_page_map.sv
// Maps a DMA source page onto the physical bus: echo RAM folds onto WRAM, and the
// mapped page picks the VRAM bus or the external bus.
module dma_page_map
    import dmg_dma_pkg::*;
(
    input  logic [7:0] page,
    output logic [7:0] mapped,
    output logic       is_vram,
    output logic       is_ext
);

    always_comb begin
        mapped  = (page >= ECHO_BASE) ? (page - ECHO_OFFSET) : page;
        is_vram = (mapped[7:5] == VRAM_PAGE_HI);
        is_ext  = !is_vram;
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write latches a page, a start delay counts M-cycle ticks,
// then LEN source addresses are issued and each fetched byte is written into OAM.
module oam_dma_ctrl
    import dmg_dma_pkg::*;
#(
    parameter int LEN         = OAM_LEN,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        mcyc,
    input  logic        ff46_wr,
    input  logic [7:0]  cpu_d_in,
    input  logic [7:0]  dma_d_in,
    output logic [7:0]  reg_d_out,
    output logic [15:0] dma_a,
    output logic        dma_addr_ext,
    output logic        dma_addr_vram,
    output logic        dma_run,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_wr
);

    localparam logic [8:0] LAST_IDX  = 9'(LEN - 1);
    localparam logic [7:0] DELAY_INI = 8'(START_DELAY);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] act_page_q, act_page_d;
    logic [8:0] idx_q, idx_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       pending_q, pending_d;

    logic       start;
    logic       last_tick;
    logic       run_next;
    logic [7:0] mapped_page;
    logic       src_vram;
    logic       src_ext;

    dma_page_map u_page_map (
        .page    (act_page_q),
        .mapped  (mapped_page),
        .is_vram (src_vram),
        .is_ext  (src_ext)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            page_q     <= FF46_RESET;
            act_page_q <= 8'h00;
            idx_q      <= 9'd0;
            dcnt_q     <= 8'd0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            act_page_q <= act_page_d;
            idx_q      <= idx_d;
            dcnt_q     <= dcnt_d;
            pending_q  <= pending_d;
        end
    end

    // The delay counter runs alongside RUN so a restart can overlap an active transfer.
    always_comb begin
        page_d     = page_q;
        act_page_d = act_page_q;
        idx_d      = idx_q;
        dcnt_d     = dcnt_q;
        pending_d  = pending_q;
        start      = 1'b0;
        last_tick  = dma_run && mcyc && (idx_q == LAST_IDX);

        if (dma_run && mcyc) begin
            idx_d = idx_q + 9'd1;
        end

        if (ff46_wr) begin
            page_d    = cpu_d_in;
            pending_d = 1'b1;
            dcnt_d    = DELAY_INI;
        end else if (pending_q && mcyc) begin
            if (dcnt_q != 8'd0) begin
                dcnt_d = dcnt_q - 8'd1;
            end else begin
                pending_d  = 1'b0;
                start      = 1'b1;
                act_page_d = page_q;
                idx_d      = 9'd0;
            end
        end

        // A start on the final tick keeps the run alive with the new page.
        run_next = start || (dma_run && !last_tick);
        if (run_next) begin
            state_d = RUN;
        end else if (pending_d) begin
            state_d = DELAY;
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        dma_run       = (state_q == RUN);
        reg_d_out     = page_q;
        dma_a         = dma_run ? {mapped_page, idx_q[7:0]} : 16'h0000;
        dma_addr_ext  = dma_run && src_ext;
        dma_addr_vram = dma_run && src_vram;
        oam_wr        = dma_run && mcyc;
        oam_a         = oam_wr ? idx_q[7:0] : 8'h00;
        oam_d         = oam_wr ? dma_d_in : 8'h00;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl; expected OAM writes are queued per M-cycle and
// checked by a monitor when the DUT strobes oam_wr.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        nreset;
    logic        mcyc;
    logic        ff46_wr;
    logic [7:0]  cpu_d_in;
    logic [7:0]  dma_d_in;
    logic [7:0]  reg_d_out;
    logic [15:0] dma_a;
    logic        dma_addr_ext;
    logic        dma_addr_vram;
    logic        dma_run;
    logic [7:0]  oam_a;
    logic [7:0]  oam_d;
    logic        oam_wr;

    typedef struct packed {
        logic [7:0]  k;
        logic [7:0]  d;
        logic [15:0] a;
    } wr_t;

    wr_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk           (clk),
        .nreset        (nreset),
        .mcyc          (mcyc),
        .ff46_wr       (ff46_wr),
        .cpu_d_in      (cpu_d_in),
        .dma_d_in      (dma_d_in),
        .reg_d_out     (reg_d_out),
        .dma_a         (dma_a),
        .dma_addr_ext  (dma_addr_ext),
        .dma_addr_vram (dma_addr_vram),
        .dma_run       (dma_run),
        .oam_a         (oam_a),
        .oam_d         (oam_d),
        .oam_wr        (oam_wr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A write is expected exactly on mcyc clocks for which stimulus queued one.
    always @(negedge clk) begin
        wr_t e;
        if (mcyc && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("oam_wr", 16'(oam_wr), 16'h0001);
            chk("oam_a", 16'(oam_a), 16'(e.k));
            chk("oam_d", 16'(oam_d), 16'(e.d));
            chk("dma_a_tick", dma_a, e.a);
        end else begin
            chk("oam_wr_idle", 16'(oam_wr), 16'h0000);
        end
    end

    // One M-cycle of 4 clks, tick on the last; optional FF46 write on clk wclk.
    task automatic mc(input bit wr, input logic [7:0] wv, input int wclk,
                      input bit er, input logic [7:0] ep, input int ek, input bit ev);
        logic [7:0] data;
        wr_t        e;
        data     = 8'($urandom_range(0, 255));
        dma_d_in = data;
        cpu_d_in = wv;
        if (er) begin
            e.k = 8'(ek);
            e.d = data;
            e.a = {ep, 8'(ek)};
            sb_q.push_back(e);
        end
        for (int c = 0; c < 4; c++) begin
            mcyc    = (c == 3);
            ff46_wr = wr && (c == wclk);
            @(negedge clk);
            if (c == 0) begin
                chk("dma_run", 16'(dma_run), 16'(er));
                chk("dma_a", dma_a, er ? {ep, 8'(ek)} : 16'h0000);
                chk("dma_addr_ext", 16'(dma_addr_ext), 16'(er && !ev));
                chk("dma_addr_vram", 16'(dma_addr_vram), 16'(er && ev));
            end
            @(posedge clk);
            #1;
        end
        mcyc    = 1'b0;
        ff46_wr = 1'b0;
    endtask

    task automatic idle_mc();
        mc(1'b0, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic transfer(input logic [7:0] wv, input logic [7:0] mp, input bit ev);
        mc(1'b1, wv, 0, 1'b0, 8'h00, 0, 1'b0);
        idle_mc();
        for (int k = 0; k < 160; k++) mc(1'b0, 8'h00, 0, 1'b1, mp, k, ev);
        idle_mc();
        chk("reg_d_out", 16'(reg_d_out), 16'(wv));
        $display("[TB] transfer page %h -> source %h00 done", wv, mp);
    endtask

    initial begin
        nreset   = 1'b0;
        mcyc     = 1'b0;
        ff46_wr  = 1'b0;
        cpu_d_in = 8'h00;
        dma_d_in = 8'h00;
        #12;
        chk("rst_reg_d_out", 16'(reg_d_out), 16'h00FF);
        chk("rst_dma_run", 16'(dma_run), 16'h0000);
        chk("rst_dma_a", dma_a, 16'h0000);
        chk("rst_ext", 16'(dma_addr_ext), 16'h0000);
        chk("rst_vram", 16'(dma_addr_vram), 16'h0000);
        chk("rst_oam_a", 16'(oam_a), 16'h0000);
        chk("rst_oam_d", 16'(oam_d), 16'h0000);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (3) idle_mc();
        chk("idle_reg_d_out", 16'(reg_d_out), 16'h00FF);

        transfer(8'hC1, 8'hC1, 1'b0);
        transfer(8'h80, 8'h80, 1'b1);
        transfer(8'hFE, 8'hDE, 1'b0);

        // Restart mid-run: two more old-page writes, then the new page from index 0.
        mc(1'b1, 8'hC0, 0, 1'b0, 8'h00, 0, 1'b0);
        idle_mc();
        for (int k = 0; k < 50; k++) mc(1'b0, 8'h00, 0, 1'b1, 8'hC0, k, 1'b0);
        mc(1'b1, 8'hD0, 0, 1'b1, 8'hC0, 50, 1'b0);
        chk("restart_reg_d_out", 16'(reg_d_out), 16'h00D0);
        mc(1'b0, 8'h00, 0, 1'b1, 8'hC0, 51, 1'b0);
        for (int k = 0; k < 160; k++) mc(1'b0, 8'h00, 0, 1'b1, 8'hD0, k, 1'b0);
        idle_mc();
        $display("[TB] restart C0 -> D0 done");

        // Write coincident with a tick: that tick does not count.
        mc(1'b1, 8'h12, 3, 1'b0, 8'h00, 0, 1'b0);
        idle_mc();
        idle_mc();
        for (int k = 0; k < 77; k++) mc(1'b0, 8'h00, 0, 1'b1, 8'h12, k, 1'b0);
        $display("[TB] coincident-tick start page 12 done");

        // Asynchronous reset in the middle of M-cycle 77.
        chk("run_before_rst", 16'(dma_run), 16'h0001);
        dma_d_in = 8'h5A;
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_dma_run", 16'(dma_run), 16'h0000);
        chk("arst_dma_a", dma_a, 16'h0000);
        chk("arst_ext", 16'(dma_addr_ext), 16'h0000);
        chk("arst_oam_a", 16'(oam_a), 16'h0000);
        chk("arst_reg_d_out", 16'(reg_d_out), 16'h00FF);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (4) idle_mc();
        chk("post_rst_run", 16'(dma_run), 16'h0000);
        chk("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("[TB] async reset mid-run done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
